// File: rtl/fft_result_serializer.sv
// FFT result serializer: double-buffered capture of a full FFT frame, streamed out one
// complex sample per beat in either bit-reversed or natural lane order.
module fft_result_serializer #(
    parameter int unsigned FORMAT_WIDTH = 9,
    parameter int unsigned LANES        = 32,
    parameter int unsigned BITREV       = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          frame_valid,
    input  logic [FORMAT_WIDTH*LANES-1:0] frame_real,
    input  logic [FORMAT_WIDTH*LANES-1:0] frame_imag,
    output logic                          frame_ready,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [FORMAT_WIDTH-1:0]       out_real,
    output logic [FORMAT_WIDTH-1:0]       out_imag,
    output logic [$clog2(LANES)-1:0]      out_index,
    output logic                          out_last,
    output logic                          overflow
);
    localparam int unsigned   IW      = $clog2(LANES);
    localparam logic [IW-1:0] LastIdx = IW'(LANES - 1);

    typedef enum logic {StIdle, StStream} state_t;

    logic [FORMAT_WIDTH*LANES-1:0] bank_real [2];
    logic [FORMAT_WIDTH*LANES-1:0] bank_imag [2];
    logic [1:0]                    full_q;
    logic [1:0]                    full_d;
    logic                          cap_ptr;
    logic                          rd_ptr;
    state_t                        state;
    logic [IW-1:0]                 n;
    logic                          overflow_q;
    logic                          capture;
    logic                          accept;
    logic                          release_last;
    logic                          next_pending;
    logic [IW-1:0]                 lane;

    function automatic logic [IW-1:0] bit_rev(input logic [IW-1:0] v);
        logic [IW-1:0] r;
        for (int i = 0; i < int'(IW); i++) begin
            r[i] = v[IW-1-i];
        end
        return r;
    endfunction

    // Ready depends only on the registered flags; a same-cycle release does not count.
    assign frame_ready  = ~(full_q[0] & full_q[1]);
    assign capture      = frame_valid & frame_ready;
    assign out_valid    = (state == StStream);
    assign accept       = out_valid & out_ready;
    assign release_last = accept & (n == LastIdx);
    // Other bank already holds a frame, or is being filled on this very edge.
    assign next_pending = full_q[~rd_ptr] | (capture & (cap_ptr != rd_ptr));
    assign lane         = (BITREV != 0) ? bit_rev(n) : n;
    assign out_index    = n;
    assign out_last     = out_valid & (n == LastIdx);
    assign overflow     = overflow_q;

    // Next full flags: capture only targets a clear bank, so it never collides with release.
    always_comb begin
        full_d = full_q;
        if (release_last) full_d[rd_ptr] = 1'b0;
        if (capture)      full_d[cap_ptr] = 1'b1;
    end

    // Bank flags, capture pointer and sticky overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_q     <= 2'b00;
            cap_ptr    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            full_q <= full_d;
            if (capture) cap_ptr <= ~cap_ptr;
            if (frame_valid && !frame_ready) overflow_q <= 1'b1;
        end
    end

    // Frame storage; contents are only observed while the matching flag is set.
    always_ff @(posedge clk) begin
        if (capture) begin
            bank_real[cap_ptr] <= frame_real;
            bank_imag[cap_ptr] <= frame_imag;
        end
    end

    // Read FSM: walks n over the read bank and hands over to the other bank without a gap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= StIdle;
            rd_ptr <= 1'b0;
            n      <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    n <= '0;
                    if (full_q[rd_ptr]) state <= StStream;
                end
                StStream: begin
                    if (accept) begin
                        if (n == LastIdx) begin
                            n      <= '0;
                            rd_ptr <= ~rd_ptr;
                            if (!next_pending) state <= StIdle;
                        end else begin
                            n <= n + 1'b1;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Sample mux; zero when no beat is being presented.
    always_comb begin
        out_real = '0;
        out_imag = '0;
        if (out_valid) begin
            out_real = bank_real[rd_ptr][FORMAT_WIDTH*(LANES-1-32'(lane)) +: FORMAT_WIDTH];
            out_imag = bank_imag[rd_ptr][FORMAT_WIDTH*(LANES-1-32'(lane)) +: FORMAT_WIDTH];
        end
    end

endmodule

// File: tb/tb_fft_result_serializer.sv
// Self-checking bench: a frame-queue model predicts every beat of two instances
// (bit-reversed and natural order); directed tests pin the model with literal values.
module tb_fft_result_serializer;
    localparam int FW    = 9;
    localparam int LANES = 32;
    localparam int VW    = FW * LANES;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          frame_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [VW-1:0] frame_real = '0;
    logic [VW-1:0] frame_imag = '0;

    logic          a_frame_ready, a_out_valid, a_out_last, a_overflow;
    logic [FW-1:0] a_out_real, a_out_imag;
    logic [4:0]    a_out_index;
    logic          b_frame_ready, b_out_valid, b_out_last, b_overflow;
    logic [FW-1:0] b_out_real, b_out_imag;
    logic [4:0]    b_out_index;

    fft_result_serializer #(.FORMAT_WIDTH(FW), .LANES(LANES), .BITREV(1)) dut_rev (
        .clk(clk), .rst(rst), .frame_valid(frame_valid), .frame_real(frame_real),
        .frame_imag(frame_imag), .frame_ready(a_frame_ready), .out_valid(a_out_valid),
        .out_ready(out_ready), .out_real(a_out_real), .out_imag(a_out_imag),
        .out_index(a_out_index), .out_last(a_out_last), .overflow(a_overflow)
    );

    fft_result_serializer #(.FORMAT_WIDTH(FW), .LANES(LANES), .BITREV(0)) dut_nat (
        .clk(clk), .rst(rst), .frame_valid(frame_valid), .frame_real(frame_real),
        .frame_imag(frame_imag), .frame_ready(b_frame_ready), .out_valid(b_out_valid),
        .out_ready(out_ready), .out_real(b_out_real), .out_imag(b_out_imag),
        .out_index(b_out_index), .out_last(b_out_last), .overflow(b_overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rev5(input int v);
        int r = 0;
        for (int b = 0; b < 5; b++) r = r * 2 + ((v >> b) & 1);
        return r;
    endfunction

    // Frame id selects the data: lane k real = 40*id + k, imag = that + 100.
    function automatic int sample(input int id, input int lane, input bit im);
        return (id * 40 + lane + (im ? 100 : 0)) % 512;
    endfunction

    int cur_id = 0;

    task automatic load_frame(input int id);
        cur_id = id;
        for (int k = 0; k < LANES; k++) begin
            frame_real[FW*(LANES-1-k) +: FW] = FW'(sample(id, k, 1'b0));
            frame_imag[FW*(LANES-1-k) +: FW] = FW'(sample(id, k, 1'b1));
        end
    endtask

    // ---------------- model: queue of held frame ids plus stream position
    int held[$];
    bit m_stream = 1'b0;
    int m_n = 0;
    bit m_ovf = 1'b0;
    int m_pre;
    bit m_cap, m_rel;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            held.delete();
            m_stream = 1'b0;
            m_n = 0;
            m_ovf = 1'b0;
        end else begin
            m_pre = held.size();
            m_cap = frame_valid && (m_pre < 2);
            m_rel = m_stream && out_ready && (m_n == LANES - 1);
            if (frame_valid && !m_cap) m_ovf = 1'b1;
            if (m_stream && out_ready) begin
                if (m_rel) begin
                    void'(held.pop_front());
                    m_n = 0;
                end else begin
                    m_n++;
                end
            end
            if (m_cap) held.push_back(cur_id);
            if (m_stream) begin
                if (m_rel) m_stream = (held.size() > 0);
            end else begin
                m_stream = (m_pre > 0);
                m_n = 0;
            end
        end
    end

    // ---------------- compare process, once per cycle on the falling edge
    logic          p_valid = 1'b0, p_ready = 1'b0;
    logic [FW-1:0] p_real = '0;
    logic [4:0]    p_idx = '0;
    int            c_id;

    always @(negedge clk) begin
        chk("frame_ready_rev", int'(a_frame_ready), int'(held.size() < 2));
        chk("frame_ready_nat", int'(b_frame_ready), int'(held.size() < 2));
        chk("overflow_rev", int'(a_overflow), int'(m_ovf));
        chk("overflow_nat", int'(b_overflow), int'(m_ovf));
        chk("valid_rev", int'(a_out_valid), int'(m_stream));
        chk("valid_nat", int'(b_out_valid), int'(m_stream));
        if (m_stream && held.size() > 0) begin
            c_id = held[0];
            chk("index_rev", int'(a_out_index), m_n);
            chk("index_nat", int'(b_out_index), m_n);
            chk("last_rev", int'(a_out_last), int'(m_n == LANES - 1));
            chk("last_nat", int'(b_out_last), int'(m_n == LANES - 1));
            chk("real_rev", int'(a_out_real), sample(c_id, rev5(m_n), 1'b0));
            chk("imag_rev", int'(a_out_imag), sample(c_id, rev5(m_n), 1'b1));
            chk("real_nat", int'(b_out_real), sample(c_id, m_n, 1'b0));
            chk("imag_nat", int'(b_out_imag), sample(c_id, m_n, 1'b1));
        end
        if (rst && p_valid && !p_ready) begin
            chk("hold_real", int'(a_out_real), int'(p_real));
            chk("hold_index", int'(a_out_index), int'(p_idx));
        end
        p_valid = a_out_valid;
        p_ready = out_ready;
        p_real  = a_out_real;
        p_idx   = a_out_index;
    end

    // ---------------- stimulus helpers
    task automatic pulse(input int id);
        @(posedge clk); #1;
        load_frame(id);
        frame_valid = 1'b1;
        @(posedge clk); #1;
        frame_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic wait_index(input int idx, output bit found);
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            if (a_out_valid && int'(a_out_index) == idx) found = 1'b1;
        end
        if (!found) chk("wait_index_timeout", 0, 1);
    endtask

    task automatic count_beats(input int cycles, output int cnt);
        cnt = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (a_out_valid && out_ready) cnt++;
        end
    endtask

    int ra[64];
    int rb[32];
    int ib[32];
    int cnt, first, last, lastpos, nlast;
    bit found;

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_valid", int'(a_out_valid), 0);
        chk("rst_last", int'(a_out_last), 0);
        chk("rst_index", int'(a_out_index), 0);
        chk("rst_real", int'(a_out_real), 0);
        chk("rst_imag", int'(a_out_imag), 0);
        chk("rst_overflow", int'(a_overflow), 0);
        chk("rst_ready", int'(a_frame_ready), 1);
        chk("rst_valid_nat", int'(b_out_valid), 0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Single frame, full throughput
        out_ready = 1'b1;
        pulse(0);
        @(negedge clk);
        chk("latency_idle", int'(a_out_valid), 0);
        cnt = 0; first = -1; last = -1; lastpos = -1; nlast = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (a_out_valid) begin
                if (cnt < 32) begin
                    ra[cnt] = int'(a_out_real);
                    rb[cnt] = int'(b_out_real);
                    ib[cnt] = int'(b_out_imag);
                end
                if (a_out_last) begin nlast++; lastpos = cnt; end
                if (first < 0) first = c;
                last = c;
                cnt++;
            end
        end
        chk("t1_beats", cnt, 32);
        chk("t1_first_cycle", first, 0);
        chk("t1_span", last - first, 31);
        chk("t1_nlast", nlast, 1);
        chk("t1_lastpos", lastpos, 31);
        chk("t1_rev_b0", ra[0], 0);
        chk("t1_rev_b1", ra[1], 16);
        chk("t1_rev_b2", ra[2], 8);
        chk("t1_rev_b3", ra[3], 24);
        chk("t1_rev_b4", ra[4], 4);
        chk("t1_rev_b31", ra[31], 31);
        chk("t1_nat_b5", rb[5], 5);
        chk("t1_nat_b31", rb[31], 31);
        chk("t1_nat_i0", ib[0], 100);
        chk("t1_nat_i31", ib[31], 131);

        // Backpressure: out_ready toggles every cycle
        pulse(1);
        cnt = 0;
        for (int c = 0; c < 150; c++) begin
            @(posedge clk); #1;
            out_ready = ~out_ready;
            @(negedge clk);
            if (a_out_valid && out_ready) cnt++;
        end
        chk("t2_beats", cnt, 32);

        // Three frames while stalled; the third is dropped
        @(posedge clk); #1;
        out_ready = 1'b0;
        pulse(2);
        pulse(3);
        @(negedge clk);
        chk("t3_ready_low", int'(a_frame_ready), 0);
        pulse(4);
        @(negedge clk);
        chk("t3_overflow", int'(a_overflow), 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        cnt = 0;
        for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            if (a_out_valid) begin
                if (cnt < 64) ra[cnt] = int'(b_out_real);
                cnt++;
            end
        end
        chk("t3_beats", cnt, 64);
        chk("t3_f2_first", ra[0], 80);
        chk("t3_f3_first", ra[32], 120);
        chk("t3_f3_lastbeat", ra[63], 151);

        // Strobe on the last beat with both banks busy: dropped
        do_reset();
        pulse(5);
        pulse(6);
        wait_index(31, found);
        load_frame(7);
        frame_valid = 1'b1;
        @(posedge clk); #1;
        frame_valid = 1'b0;
        @(negedge clk);
        chk("t4_overflow", int'(a_overflow), 1);
        chk("t4_next_index", int'(a_out_index), 0);
        chk("t4_next_real", int'(a_out_real), 240);
        count_beats(60, cnt);
        chk("t4_remaining", cnt, 31);

        // Strobe on the last beat with one bank free: streams with no gap
        do_reset();
        pulse(8);
        wait_index(31, found);
        load_frame(9);
        frame_valid = 1'b1;
        @(posedge clk); #1;
        frame_valid = 1'b0;
        @(negedge clk);
        chk("t4b_no_gap", int'(a_out_valid), 1);
        chk("t4b_index", int'(a_out_index), 0);
        chk("t4b_real", int'(a_out_real), 360);
        chk("t4b_overflow", int'(a_overflow), 0);
        count_beats(60, cnt);
        chk("t4b_remaining", cnt, 31);

        // Reset mid-stream
        pulse(10);
        wait_index(10, found);
        #2 rst = 1'b0;
        #1;
        chk("t5_valid", int'(a_out_valid), 0);
        chk("t5_last", int'(a_out_last), 0);
        chk("t5_index", int'(a_out_index), 0);
        chk("t5_real", int'(a_out_real), 0);
        chk("t5_imag", int'(a_out_imag), 0);
        chk("t5_ready", int'(a_frame_ready), 1);
        chk("t5_valid_nat", int'(b_out_valid), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        count_beats(20, cnt);
        chk("t5_silent", cnt, 0);
        pulse(11);
        count_beats(50, cnt);
        chk("t5_new_frame", cnt, 32);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fft_result_serializer.md
FFT_RESULT_SERIALIZER -- requirements
Module: fft_result_serializer

Interface
REQ-001 The block SHALL have parameter FORMAT_WIDTH, default 9: bit width of one custom-float sample (sign, 4-bit exponent, 4-bit significand).
REQ-002 The block SHALL have parameter LANES, default 32: samples per FFT frame; must be a power of two.
REQ-003 The block SHALL have parameter BITREV, default 1: 1 means output order is bit-reversed lane index; 0 means natural lane order.
REQ-004 Port clk, input, 1: clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous, active-low.
REQ-006 Port frame_valid, input, 1: one-cycle capture strobe from the FFT core's fft_done.
REQ-007 Port frame_real, input, FORMAT_WIDTH*LANES: real results. Lane k occupies bits [FORMAT_WIDTH*(LANES-k)-1 : FORMAT_WIDTH*(LANES-1-k)], so lane 0 is the MSB slice.
REQ-008 Port frame_imag, input, FORMAT_WIDTH*LANES: imaginary results, with the same lane packing as frame_real.
REQ-009 Port frame_ready, output, 1: at least one capture bank is free.
REQ-010 Port out_valid, output, 1: out_real, out_imag, out_index and out_last are valid.
REQ-011 Port out_ready, input, 1: downstream accepts the beat.
REQ-012 Port out_real, output, FORMAT_WIDTH: real part of the current sample.
REQ-013 Port out_imag, output, FORMAT_WIDTH: imaginary part of the current sample.
REQ-014 Port out_index, output, log2(LANES): frequency-bin number n of the current beat.
REQ-015 Port out_last, output, 1: asserted on the beat where n equals LANES-1.
REQ-016 Port overflow, output, 1: sticky flag, set when a frame is dropped.

Function
REQ-017 The block SHALL contain two capture banks (0 and 1), each with a full flag. Capture and read bank pointers SHALL each start at bank 0.
REQ-018 frame_ready SHALL equal NOT(full0 AND full1). It is derived from the registered flags only; a release in the same cycle does not raise it.
REQ-019 When frame_valid=1 and frame_ready=1, the block SHALL latch both vectors into the capture-pointer bank, set that bank's full flag, and toggle the capture pointer.
REQ-020 When frame_valid=1 and frame_ready=0, the frame SHALL be discarded, overflow SHALL be set to 1, and all stored data SHALL be unchanged.
REQ-021 The read FSM SHALL have two states. IDLE moves to STREAM when the read-pointer bank is full, and n is set to 0. STREAM moves to IDLE after the last beat is accepted, unless the other bank is full, in which case it stays in STREAM with n set to 0.
REQ-022 out_valid SHALL be 1 exactly when the FSM is in STREAM.
REQ-023 A beat is accepted when out_valid=1 and out_ready=1. On acceptance n SHALL increment; while out_ready=0 all outputs SHALL hold stable.
REQ-024 out_real and out_imag SHALL come from lane bitrev(n) of the read bank when BITREV=1, and from lane n when BITREV=0. The reversal is over log2(LANES) bits. out_index SHALL equal n.
REQ-025 On acceptance of the beat with n=LANES-1, the block SHALL clear the read bank's full flag, toggle the read pointer, and wrap n to 0.
REQ-026 Latency: a frame captured at edge t SHALL give out_valid=1 after edge t+1 when the FSM was IDLE. Back-to-back frames SHALL stream with no idle cycle between the last beat of one and the first beat of the next.
REQ-027 Capture and release in the same cycle SHALL both take effect. The capture writes only a bank whose flag was clear before that edge, so it never overwrites the bank being streamed.
REQ-028 Sample values SHALL pass through bit-exact; the block performs no arithmetic on data.

Reset
REQ-029 When rst=0, the block SHALL asynchronously force: full flags 0, both pointers 0, FSM IDLE, n 0, out_valid 0, out_last 0, out_index 0, out_real 0, out_imag 0, overflow 0, frame_ready 1.
REQ-030 Reset asserted mid-stream SHALL discard both banks. After rst returns to 1, no beat SHALL be issued until a new frame_valid arrives.
REQ-031 overflow SHALL be cleared only by reset.

Verification
REQ-032 Single frame with lane k real=k, imag=k+100, BITREV=1, out_ready=1: expect 32 beats on consecutive cycles. out_real sequence is 0,16,8,24,4,...,31; out_index is 0..31; out_last=1 only on beat 31.
REQ-033 Same frame with BITREV=0: expect out_real 0..31 in order and out_imag 100..131.
REQ-034 Backpressure: toggle out_ready every cycle. Expect outputs to hold while out_ready=0, exactly 32 accepted beats, and no duplicates or skips.
REQ-035 Three frames pulsed 2 cycles apart with out_ready=0: frames 1 and 2 are accepted. At the third pulse frame_ready=0 and overflow becomes 1. Raising out_ready then yields exactly 64 beats (frame1 then frame2); frame3 is absent.
REQ-036 Frame 2 strobed on the same cycle as frame 1's last beat with both banks busy: expect frame 2 dropped and overflow=1. Repeat with one bank free: expect frame 2 streamed immediately after frame 1 with no gap.
REQ-037 Drop rst to 0 at beat 10 of a frame: expect all outputs to reach their reset values immediately and no beats after release until a new frame_valid arrives.
